// File: rtl/spi_reg_config_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_pkg
//  Description : Shared types and constants for the SPI register-configuration
//                slave: FSM state encoding, register address map and frame
//                geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_reg_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Register address map
    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_DUTY      = 4;

    // Number of physical output registers (fixed by the port list)
    localparam int NUM_OUT_REGS   = 5;

    // Frame geometry: R/W bit, address field, 8-bit data field
    localparam int FRAME_BITS     = 16;
    localparam int DATA_W         = 8;

    // Bit counter: must represent FRAME_BITS+1 so that over-long frames
    // remain distinguishable from exact-length ones.
    localparam int CNT_W          = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

endpackage : spi_reg_pkg
`default_nettype wire

// File: rtl/spi_reg_config_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_config_if
//  Description : Bundle of the SPI pins and the configuration-register
//                outputs of spi_reg_config.
//                  sclk/copi/ncs      : SPI host -> slave (asynchronous)
//                  en_reg_* / duty    : 8-bit configuration registers
//                  frame_done/err     : one-clk status pulses
//                master modport = SPI host / register consumer side,
//                slave  modport = spi_reg_config side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_reg_config_if;

    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       frame_done;
    logic       frame_err;

    modport master (
        output sclk,
        output copi,
        output ncs,
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        input  frame_done,
        input  frame_err
    );

    modport slave (
        input  sclk,
        input  copi,
        input  ncs,
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        output frame_done,
        output frame_err
    );

endinterface : spi_reg_config_if
`default_nettype wire

// File: rtl/spi_reg_config_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Multi-flop synchronizer for an asynchronous input followed
//                by a delay flop for edge detection.
//  Ports       : clk, rst   - system clock, async active-high reset
//                din        - asynchronous input
//                level      - synchronized level
//                rise/fall  - one-clk pulses on synchronized edges
//  Parameters  : SYNC_STAGES (>= 2), RESET_VAL (idle level of the pin)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   dly_q;
    logic                   dly_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    // Reset to the pin's idle level so no spurious edge appears after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  =  sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall  = ~sync_q[SYNC_STAGES-1] &  dly_q;

endmodule : sync_edge
`default_nettype wire

// File: rtl/spi_reg_config.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_config
//  Description : SPI mode-0 write-only slave holding the five PWM peripheral
//                configuration registers. 16-bit frames, MSB first:
//                [15] R/W (1 = write), [14:8] address, [7:0] data.
//  Ports       : clk, rst   - system clock, async active-high reset
//                bus        - spi_reg_config_if.slave (SPI pins in,
//                             configuration registers and status pulses out)
//  Parameters  : SYNC_STAGES - synchronizer depth (>= 2)
//                ADDR_W      - address field width
//                NUM_REGS    - addresses 0..NUM_REGS-1 accept writes
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_config
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 7,
    parameter int NUM_REGS    = 5
) (
    input  logic             clk,
    input  logic             rst,
    spi_reg_config_if.slave  bus
);

    localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic w_sclk_level_unused;
    logic w_sclk_rise;
    logic w_sclk_fall_unused;
    logic w_copi_level;
    logic w_copi_rise_unused;
    logic w_copi_fall_unused;
    logic w_ncs_level;
    logic w_ncs_rise;
    logic w_ncs_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.sclk),
        .level (w_sclk_level_unused),
        .rise  (w_sclk_rise),
        .fall  (w_sclk_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.copi),
        .level (w_copi_level),
        .rise  (w_copi_rise_unused),
        .fall  (w_copi_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.ncs),
        .level (w_ncs_level),
        .rise  (w_ncs_rise),
        .fall  (w_ncs_fall)
    );

    // ------------------------------------------------------------------
    // Frame sequencer state
    // ------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [DATA_W-1:0]       regs_q [NUM_OUT_REGS];
    logic [DATA_W-1:0]       regs_d [NUM_OUT_REGS];

    // Frame fields, valid once the frame has been fully shifted in
    logic                    w_rw;
    logic [ADDR_W-1:0]       w_addr;
    logic [DATA_W-1:0]       w_data;
    logic                    w_frame_ok;

    assign w_rw       = shift_q[FRAME_BITS-1];
    assign w_addr     = shift_q[FRAME_BITS-2 -: ADDR_W];
    assign w_data     = shift_q[DATA_W-1:0];
    assign w_frame_ok = (cnt_q == CNT_FULL) && w_rw && (w_addr < NUM_REGS_A);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        regs_d  = regs_q;

        case (state_q)
            ST_IDLE: begin
                if (w_ncs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end

            ST_SHIFT: begin
                // Decide the verdict on the way into COMMIT so that the
                // status pulse is a flop output and lines up with the
                // single COMMIT cycle.
                if (w_ncs_rise) begin
                    state_d = ST_COMMIT;
                    done_d  = w_frame_ok;
                    err_d   = ~w_frame_ok;
                end else if (w_sclk_rise && !w_ncs_level) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], w_copi_level};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_COMMIT: begin
                // done_q already encodes every acceptance condition; the
                // register lands on the edge that ends this cycle.
                if (done_q) begin
                    for (int i = 0; i < NUM_OUT_REGS; i++) begin
                        if (w_addr == ADDR_W'(i)) begin
                            regs_d[i] = w_data;
                        end
                    end
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_OUT_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int i = 0; i < NUM_OUT_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
    assign bus.en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
    assign bus.en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
    assign bus.en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
    assign bus.pwm_duty_cycle  = regs_q[ADDR_DUTY];
    assign bus.frame_done      = done_q;
    assign bus.frame_err       = err_q;

endmodule : spi_reg_config
`default_nettype wire

// File: tb/tb_spi_reg_config.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_reg_config
//  Description : Directed self-checking bench for spi_reg_config.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_config;

    localparam int HALF = 6;   // clk periods per SPI half-cycle

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   done_cnt;
    int   err_cnt;
    int   done_base;
    int   err_base;

    spi_reg_config_if bus ();

    spi_reg_config #(
        .SYNC_STAGES (2),
        .ADDR_W      (7),
        .NUM_REGS    (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            done_cnt <= 0;
            err_cnt  <= 0;
        end else begin
            if (bus.frame_done) done_cnt <= done_cnt + 1;
            if (bus.frame_err)  err_cnt  <= err_cnt + 1;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        chk({tag, ".reg0"}, {24'd0, bus.en_reg_out_7_0},  {24'd0, e0});
        chk({tag, ".reg1"}, {24'd0, bus.en_reg_out_15_8}, {24'd0, e1});
        chk({tag, ".reg2"}, {24'd0, bus.en_reg_pwm_7_0},  {24'd0, e2});
        chk({tag, ".reg3"}, {24'd0, bus.en_reg_pwm_15_8}, {24'd0, e3});
        chk({tag, ".reg4"}, {24'd0, bus.pwm_duty_cycle},  {24'd0, e4});
    endtask

    // Lower ncs and clock out nbits of val MSB first; ncs stays low.
    task automatic shift_bits(input logic [31:0] val, input int nbits);
        bus.ncs = 1'b0;
        wait_clks(2 * HALF);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.copi = val[i];
            wait_clks(HALF);
            bus.sclk = 1'b1;
            wait_clks(HALF);
            bus.sclk = 1'b0;
        end
        wait_clks(2 * HALF);
    endtask

    task automatic send_frame(input logic [31:0] val, input int nbits);
        shift_bits(val, nbits);
        bus.ncs = 1'b1;
        wait_clks(2 * HALF);
    endtask

    task automatic mark();
        done_base = done_cnt;
        err_base  = err_cnt;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        bus.sclk = 1'b0;
        bus.copi = 1'b0;
        bus.ncs  = 1'b1;
        wait_clks(3);

        // Reset state
        chk_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("reset.done", {31'd0, bus.frame_done}, 32'd0);
        chk("reset.err",  {31'd0, bus.frame_err},  32'd0);
        rst = 1'b0;
        wait_clks(4);

        // Write 0x80FF, checking the exact commit cycle
        mark();
        shift_bits(32'h80FF, 16);
        bus.ncs = 1'b1;
        wait_clks(3);
        chk("lat.done_hi",  {31'd0, bus.frame_done}, 32'd1);
        chk("lat.reg0_old", {24'd0, bus.en_reg_out_7_0}, 32'h00);
        wait_clks(1);
        chk("lat.done_lo",  {31'd0, bus.frame_done}, 32'd0);
        chk("lat.reg0_new", {24'd0, bus.en_reg_out_7_0}, 32'hFF);
        wait_clks(2 * HALF);
        chk("w80FF.ndone", done_cnt - done_base, 32'd1);
        chk("w80FF.nerr",  err_cnt - err_base,   32'd0);
        chk_regs("w80FF", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);

        // Two writes: duty and pwm enable low
        mark();
        send_frame(32'h8480, 16);
        send_frame(32'h8201, 16);
        chk("w2.ndone", done_cnt - done_base, 32'd2);
        chk_regs("w2", 8'hFF, 8'h00, 8'h01, 8'h00, 8'h80);

        // Read frame and out-of-range address are both rejected
        mark();
        send_frame(32'h0055, 16);
        send_frame(32'h8755, 16);
        chk("rej.nerr",  err_cnt - err_base,   32'd2);
        chk("rej.ndone", done_cnt - done_base, 32'd0);
        chk_regs("rej", 8'hFF, 8'h00, 8'h01, 8'h00, 8'h80);

        // Short frame (10 bits) and long frame (17 bits)
        mark();
        send_frame(32'h0000_0203, 10);
        chk("short.nerr", err_cnt - err_base, 32'd1);
        send_frame(32'h0001_0155, 17);
        chk("long.nerr",  err_cnt - err_base, 32'd2);
        chk("len.ndone",  done_cnt - done_base, 32'd0);
        chk_regs("len", 8'hFF, 8'h00, 8'h01, 8'h00, 8'h80);
        send_frame(32'h81AA, 16);
        chk_regs("w81AA", 8'hFF, 8'hAA, 8'h01, 8'h00, 8'h80);

        // Reset in the middle of a frame
        shift_bits(32'h84, 8);
        rst = 1'b1;
        wait_clks(3);
        bus.ncs = 1'b1;
        wait_clks(3);
        chk_regs("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        wait_clks(4);
        mark();
        send_frame(32'h8433, 16);
        chk("post_rst.ndone", done_cnt - done_base, 32'd1);
        chk("post_rst.nerr",  err_cnt - err_base,   32'd0);
        chk_regs("post_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h33);

        // sclk activity with ncs high is ignored
        mark();
        for (int i = 0; i < 20; i++) begin
            bus.copi = i[0];
            wait_clks(HALF);
            bus.sclk = 1'b1;
            wait_clks(HALF);
            bus.sclk = 1'b0;
        end
        wait_clks(2 * HALF);
        chk("idle_sclk.ndone", done_cnt - done_base, 32'd0);
        chk("idle_sclk.nerr",  err_cnt - err_base,   32'd0);
        send_frame(32'h8377, 16);
        chk("w8377.ndone", done_cnt - done_base, 32'd1);
        chk("w8377.nerr",  err_cnt - err_base,   32'd0);
        chk_regs("w8377", 8'h00, 8'h00, 8'h00, 8'h77, 8'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_spi_reg_config
`default_nettype wire

// File: doc/spi_reg_config.md
Name: spi_reg_config

Overview:
SPI-mode-0 write-only slave that configures the PWM peripheral. It receives 16-bit frames from an external host on ui_in[2:0] and decodes address/data. It drives the five configuration registers consumed by pwm_peripheral: output enables, PWM enables and duty cycle. It sits in the top-level wrapper between the input pins and pwm_peripheral.

Parameters:
SYNC_STAGES, 2, flops in each input synchronizer (min 2)
ADDR_W, 7, frame address field width
NUM_REGS, 5, implemented registers (addresses 0..NUM_REGS-1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sclk  in  1  SPI clock (ui_in[0]), asynchronous to clk
copi  in  1  SPI data in (ui_in[1]), asynchronous
ncs  in  1  SPI chip select, active-low (ui_in[2]), asynchronous
en_reg_out_7_0  out  8  addr 0x00
en_reg_out_15_8  out  8  addr 0x01
en_reg_pwm_7_0  out  8  addr 0x02
en_reg_pwm_15_8  out  8  addr 0x03
pwm_duty_cycle  out  8  addr 0x04
frame_done  out  1  one-clk pulse on every committed write
frame_err  out  1  one-clk pulse on a rejected frame

Behaviour:
- Reset: all five registers 0x00, frame_done=0, frame_err=0, FSM=IDLE, bit counter 0, shift reg 0. Synchronizer flops reset to sclk=0, copi=0, ncs=1.
- Inputs pass through SYNC_STAGES flops, then a single delay flop for edge detection. Events: sclk_rise, ncs_fall, ncs_rise.
- Frame, MSB first: bit15 = R/W (1=write), bits14:8 = address, bits7:0 = data. COPI is sampled on synchronized sclk_rise only while ncs is low.
- Host constraint: sclk high and low phases each >= SYNC_STAGES+1 clk periods; nCS setup/hold >= 2 sclk-equivalent phases. Violations are undefined.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE -> SHIFT on ncs_fall; clear counter and shift reg.
- SHIFT: each sclk_rise shifts in 1 bit and increments a 5-bit counter, which saturates at 17.
- SHIFT -> COMMIT on ncs_rise.
- COMMIT (1 clk): if count==16, R/W=1 and address<NUM_REGS, write data to that register and pulse frame_done. Otherwise pulse frame_err and leave all registers unchanged. Then return to IDLE.
- Rejected-frame causes: count<16, count>16, R/W=0 (reads unsupported), address >= NUM_REGS.
- Latency: the register takes its new value at the clk edge ending COMMIT, SYNC_STAGES+2 clk after the raw ncs rising edge. frame_done/frame_err are asserted during that same cycle.
- sclk edges while ncs is high are ignored. A ncs_fall during COMMIT cannot occur under the host constraint.
- Reset mid-frame: immediate return to reset state, partial frame discarded, registers cleared.
- Registers hold their value indefinitely; there is no read-back path.

Decomposition:
- Package spi_reg_pkg: state enum (IDLE/SHIFT/COMMIT); address constants ADDR_EN_OUT_LO=0, ADDR_EN_OUT_HI=1, ADDR_EN_PWM_LO=2, ADDR_EN_PWM_HI=3, ADDR_DUTY=4; FRAME_BITS=16.
- Sub-module sync_edge: parameterized SYNC_STAGES synchronizer plus rise/fall detect. Instantiated three times (sclk, copi, ncs); copi uses only the level output.

Test Plan:
- Reset, then write frame 0x80FF -> en_reg_out_7_0=0xFF and frame_done pulses once; all other registers remain 0x00.
- Write 0x8480 then 0x8201 -> pwm_duty_cycle=0x80 and en_reg_pwm_7_0=0x01; registers 0x01 and 0x03 remain 0x00.
- Read frame 0x0055, then write to invalid address 0x8755 -> frame_err pulses twice; no register changes.
- Short frame: 10 bits then ncs high -> frame_err, no change. 17-bit frame 0x80AA plus an extra bit -> frame_err, no change. Next valid 0x81AA -> en_reg_out_15_8=0xAA.
- Assert rst after 8 bits of 0x84FF, release it, then send full 0x8433 -> pwm_duty_cycle=0x33 with no residue from the aborted frame.
- sclk toggling with ncs high, then a valid 0x8377 -> only en_reg_pwm_15_8=0x77, and exactly one frame_done pulse.
